pixel_writer: RTL and testbench

Downstream stage of the line-drawing engine: consumes its (x, y, write-strobe) pixel stream and turns it into framebuffer write transactions for the VGA adapter memory port. It clips off-screen pixels, suppresses consecutive duplicates (the drawer repeats its end point while holding `complete`), and buffers pixels in a small FIFO so memory back-pressure never loses a pixel. It computes the linear framebuffer address and reports when a line has been fully committed.

---
 rtl/pixel_writer_if.sv | 27 ++
 rtl/pixel_writer.sv | 141 ++++++++++++++
 tb/tb_pixel_writer.sv | 339 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pixel_writer_if.sv
// Pixel stream and framebuffer write port of the pixel writer.
// The slave modport is the pixel writer. The master modport is its environment,
// which is the line drawer on the pixel side and the memory on the fb side.
interface pixel_writer_if #(
    parameter int COLOR_W = 3,
    parameter int ADDR_W  = 15
);
    logic               pix_valid;
    logic               pix_ready;
    logic [8:0]         pix_x;
    logic [8:0]         pix_y;
    logic [COLOR_W-1:0] pix_color;
    logic               fb_we;
    logic [ADDR_W-1:0]  fb_addr;
    logic [COLOR_W-1:0] fb_data;
    logic               fb_ready;

    modport slave (
        input  pix_valid, pix_x, pix_y, pix_color, fb_ready,
        output pix_ready, fb_we, fb_addr, fb_data
    );

    modport master (
        output pix_valid, pix_x, pix_y, pix_color, fb_ready,
        input  pix_ready, fb_we, fb_addr, fb_data
    );
endinterface

// File: rtl/pixel_writer.sv
// Pixel writer: clips off-screen pixels and drops consecutive duplicates.
// Surviving pixels are buffered in a small FIFO and issued as framebuffer
// write requests through a registered output stage.
module pixel_writer #(
    parameter int H_RES   = 160,
    parameter int V_RES   = 120,
    parameter int DEPTH   = 8,
    parameter int COLOR_W = 3,
    parameter int ADDR_W  = 15
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          line_done,
    pixel_writer_if.slave bus,
    output logic [15:0]   clipped_cnt,
    output logic          busy,
    output logic          done
);
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int ENTRY_W = ADDR_W + COLOR_W;

    // FIFO storage; the output register acts as its registered read port
    logic [ENTRY_W-1:0] fifo_mem [DEPTH];
    logic [PTR_W:0]     wr_ptr_reg;
    logic [PTR_W:0]     rd_ptr_reg;

    logic               hist_valid_reg;
    logic [8:0]         hist_x_reg;
    logic [8:0]         hist_y_reg;
    logic [15:0]        clipped_cnt_reg;
    logic               line_seen_reg;
    logic               fb_we_reg;
    logic [ADDR_W-1:0]  fb_addr_reg;
    logic [COLOR_W-1:0] fb_data_reg;

    logic               fifo_empty;
    logic               fifo_full;
    logic               accept;
    logic               off_screen;
    logic               hist_hit;
    logic               push;
    logic               pop;
    logic [ADDR_W-1:0]  addr_wr;

    // Handshake, clip, dedup and pop decisions for the current cycle
    always_comb begin
        fifo_empty = (wr_ptr_reg == rd_ptr_reg);
        // Full comes only from the registered pointers, so a pop in this
        // cycle does not free a slot for this cycle's pixel.
        fifo_full  = (wr_ptr_reg[PTR_W-1:0] == rd_ptr_reg[PTR_W-1:0]) &&
                     (wr_ptr_reg[PTR_W] != rd_ptr_reg[PTR_W]);
        accept     = bus.pix_valid && !fifo_full;
        off_screen = (32'(bus.pix_x) >= 32'(H_RES)) || (32'(bus.pix_y) >= 32'(V_RES));
        // A start in this cycle already invalidates the history for this pixel
        hist_hit   = hist_valid_reg && !start &&
                     (bus.pix_x == hist_x_reg) && (bus.pix_y == hist_y_reg);
        push       = accept && !off_screen && !hist_hit;
        pop        = !fifo_empty && (!fb_we_reg || bus.fb_ready);
        // The product is truncated to ADDR_W. This matches the low bits of the full product.
        addr_wr    = ADDR_W'(bus.pix_y) * ADDR_W'(H_RES) + ADDR_W'(bus.pix_x);
    end

    // FIFO data write. This block has no reset, so the array can map onto block RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg[PTR_W-1:0]] <= {addr_wr, bus.pix_color};
        end
    end

    // FIFO pointers. A reset empties the buffer immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

    // Dedup history. It records the last pushed coordinate and is cleared by start.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hist_valid_reg <= 1'b0;
            hist_x_reg     <= '0;
            hist_y_reg     <= '0;
        end else if (push) begin
            hist_valid_reg <= 1'b1;
            hist_x_reg     <= bus.pix_x;
            hist_y_reg     <= bus.pix_y;
        end else if (start) begin
            hist_valid_reg <= 1'b0;
        end
    end

    // Saturating clip counter. A clip in the same cycle as start counts as one.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clipped_cnt_reg <= '0;
        end else if (start) begin
            clipped_cnt_reg <= (accept && off_screen) ? 16'd1 : 16'd0;
        end else if (accept && off_screen && (clipped_cnt_reg != 16'hFFFF)) begin
            clipped_cnt_reg <= clipped_cnt_reg + 16'd1;
        end
    end

    // Line-end flag. It latches line_done until the next start, and start has priority.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            line_seen_reg <= 1'b0;
        end else if (start) begin
            line_seen_reg <= 1'b0;
        end else if (line_done) begin
            line_seen_reg <= 1'b1;
        end
    end

    // Output request register. It reloads when idle or when the current write is
    // accepted, and it holds addr and data while the memory stalls.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fb_we_reg   <= 1'b0;
            fb_addr_reg <= '0;
            fb_data_reg <= '0;
        end else if (pop) begin
            fb_we_reg                  <= 1'b1;
            {fb_addr_reg, fb_data_reg} <= fifo_mem[rd_ptr_reg[PTR_W-1:0]];
        end else if (bus.fb_ready) begin
            fb_we_reg <= 1'b0;
        end
    end

    assign bus.pix_ready = !fifo_full;
    assign bus.fb_we     = fb_we_reg;
    assign bus.fb_addr   = fb_addr_reg;
    assign bus.fb_data   = fb_data_reg;
    assign clipped_cnt   = clipped_cnt_reg;
    assign busy          = !fifo_empty || fb_we_reg;
    assign done          = line_seen_reg && fifo_empty && !fb_we_reg;
endmodule

// File: tb/tb_pixel_writer.sv
// Self-checking bench for pixel_writer. It uses a vector table, hand-written
// corner-case sequences and randomized traffic. A negedge scoreboard checks
// every write, the clip count, busy and done against a reference model.
module tb_pixel_writer;
    localparam int H_RES   = 160;
    localparam int V_RES   = 120;
    localparam int DEPTH   = 8;
    localparam int COLOR_W = 3;
    localparam int ADDR_W  = 15;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        line_done;
    logic [15:0] clipped_cnt;
    logic        busy;
    logic        done;

    pixel_writer_if #(.COLOR_W(COLOR_W), .ADDR_W(ADDR_W)) bus ();

    pixel_writer #(
        .H_RES(H_RES), .V_RES(V_RES), .DEPTH(DEPTH),
        .COLOR_W(COLOR_W), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .line_done(line_done),
        .bus(bus), .clipped_cnt(clipped_cnt), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model. Writes are expected strictly in order. Each pixel is clipped,
    // or deduplicated against the last written coordinate, or queued for writing.
    logic [ADDR_W+COLOR_W-1:0] exp_q[$];
    int          wr_log[$];
    int          wr_count  = 0;
    int          last_addr = 0;
    int          last_data = 0;
    bit          m_hist_v  = 0;
    int          m_hist_x  = 0;
    int          m_hist_y  = 0;
    int          m_clip    = 0;
    bit          m_seen    = 0;

    // Negedge scoreboard. It compares the state after the last edge, then applies
    // the transfers that the next edge will perform.
    always @(negedge clk) begin
        if (!reset) begin
            exp_q.delete();
            m_hist_v = 0;
            m_clip   = 0;
            m_seen   = 0;
        end else begin
            check("clipped_cnt", 32'(clipped_cnt), 32'(m_clip));
            check("busy", 32'(busy), 32'(exp_q.size() != 0));
            check("done", 32'(done), 32'(m_seen && exp_q.size() == 0));
            if (bus.fb_we && bus.fb_ready) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL unexpected_write: got addr %0d data %0d expected no write",
                             bus.fb_addr, bus.fb_data);
                end else begin
                    if ({bus.fb_addr, bus.fb_data} !== exp_q[0]) begin
                        n_errors++;
                        $display("FAIL write_order: got addr %0d data %0d expected addr %0d data %0d",
                                 bus.fb_addr, bus.fb_data,
                                 exp_q[0][ADDR_W+COLOR_W-1:COLOR_W], exp_q[0][COLOR_W-1:0]);
                    end
                    void'(exp_q.pop_front());
                end
                wr_count++;
                last_addr = int'(bus.fb_addr);
                last_data = int'(bus.fb_data);
                wr_log.push_back(int'(bus.fb_addr));
            end
            if (start) begin
                m_hist_v = 0;
                m_clip   = 0;
            end
            if (bus.pix_valid && bus.pix_ready) begin
                if (int'(bus.pix_x) >= H_RES || int'(bus.pix_y) >= V_RES) begin
                    if (m_clip < 65535) m_clip++;
                end else if (!(m_hist_v && m_hist_x == int'(bus.pix_x) && m_hist_y == int'(bus.pix_y))) begin
                    exp_q.push_back({ADDR_W'(int'(bus.pix_y) * H_RES + int'(bus.pix_x)), bus.pix_color});
                    m_hist_v = 1;
                    m_hist_x = int'(bus.pix_x);
                    m_hist_y = int'(bus.pix_y);
                end
            end
            if (start)          m_seen = 0;
            else if (line_done) m_seen = 1;
        end
    end

    // Present one pixel from posedge+1 until it is accepted or the bound expires.
    // The start input is high for the first cycle only.
    task automatic send(input int x, input int y, input int c, input bit st,
                        input int bound, output bit ok);
        bus.pix_valid = 1'b1;
        bus.pix_x     = 9'(x);
        bus.pix_y     = 9'(y);
        bus.pix_color = COLOR_W'(c);
        start         = st;
        ok            = 1'b0;
        for (int k = 0; k < bound && !ok; k++) begin
            @(negedge clk);
            ok = bus.pix_ready;
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        bus.pix_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 60; k++) begin
            if (!busy) break;
            @(posedge clk);
            #1;
        end
        check("drain_idle", 32'(busy), 32'd0);
    endtask

    typedef struct packed {
        logic [8:0]  x;
        logic [8:0]  y;
        logic [2:0]  c;
        logic        st;
        logic        w;
        logic [14:0] addr;
        logic [15:0] clip;
    } vec_t;

    vec_t tbl[13];

    initial begin
        bit ok;
        int base;
        int acc;
        int rx;
        int ry;

        // Vector table: {x, y, colour, start, write expected, addr, clipped_cnt after}
        tbl[0]  = '{9'd10,  9'd5,   3'd3, 1'b1, 1'b1, 15'd810,   16'd0};
        tbl[1]  = '{9'd159, 9'd119, 3'd1, 1'b0, 1'b1, 15'd19199, 16'd0};
        tbl[2]  = '{9'd160, 9'd0,   3'd2, 1'b0, 1'b0, 15'd0,     16'd1};
        tbl[3]  = '{9'd0,   9'd120, 3'd2, 1'b0, 1'b0, 15'd0,     16'd2};
        tbl[4]  = '{9'd511, 9'd511, 3'd2, 1'b0, 1'b0, 15'd0,     16'd3};
        tbl[5]  = '{9'd3,   9'd3,   3'd2, 1'b1, 1'b1, 15'd483,   16'd0};
        tbl[6]  = '{9'd3,   9'd3,   3'd5, 1'b0, 1'b0, 15'd0,     16'd0};
        tbl[7]  = '{9'd3,   9'd3,   3'd6, 1'b1, 1'b1, 15'd483,   16'd0};
        tbl[8]  = '{9'd200, 9'd5,   3'd1, 1'b1, 1'b0, 15'd0,     16'd1};
        tbl[9]  = '{9'd3,   9'd3,   3'd4, 1'b0, 1'b1, 15'd483,   16'd1};
        tbl[10] = '{9'd159, 9'd0,   3'd7, 1'b0, 1'b1, 15'd159,   16'd1};
        tbl[11] = '{9'd0,   9'd119, 3'd1, 1'b0, 1'b1, 15'd19040, 16'd1};
        tbl[12] = '{9'd3,   9'd3,   3'd0, 1'b0, 1'b1, 15'd483,   16'd1};

        reset         = 1'b0;
        start         = 1'b0;
        line_done     = 1'b0;
        bus.pix_valid = 1'b0;
        bus.pix_x     = '0;
        bus.pix_y     = '0;
        bus.pix_color = '0;
        bus.fb_ready  = 1'b0;

        // Check the reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_fb_we", 32'(bus.fb_we), 32'd0);
        check("rst_fb_addr", 32'(bus.fb_addr), 32'd0);
        check("rst_fb_data", 32'(bus.fb_data), 32'd0);
        check("rst_clipped", 32'(clipped_cnt), 32'd0);
        check("rst_pix_ready", 32'(bus.pix_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        reset        = 1'b1;
        bus.fb_ready = 1'b1;
        @(posedge clk);
        #1;

        // Single pixel: the write appears one cycle after acceptance and lasts one cycle
        send(10, 5, 3, 1'b1, 1, ok);
        check("single_accept", 32'(ok), 32'd1);
        check("single_we_n0", 32'(bus.fb_we), 32'd0);
        @(posedge clk);
        #1;
        check("single_we_n1", 32'(bus.fb_we), 32'd1);
        check("single_addr", 32'(bus.fb_addr), 32'd810);
        check("single_data", 32'(bus.fb_data), 32'd3);
        @(posedge clk);
        #1;
        check("single_we_n2", 32'(bus.fb_we), 32'd0);

        // Table-driven clip and dedup vectors
        for (int i = 0; i < 13; i++) begin
            base = wr_count;
            send(int'(tbl[i].x), int'(tbl[i].y), int'(tbl[i].c), tbl[i].st, 1, ok);
            check("tbl_accept", 32'(ok), 32'd1);
            repeat (3) @(posedge clk);
            #1;
            check("tbl_writes", 32'(wr_count - base), 32'(tbl[i].w));
            if (tbl[i].w) begin
                check("tbl_addr", 32'(last_addr), 32'(tbl[i].addr));
                check("tbl_data", 32'(last_data), 32'(tbl[i].c));
            end
            check("tbl_clipped", 32'(clipped_cnt), 32'(tbl[i].clip));
        end

        // A start returns clipped_cnt to zero
        send(400, 0, 0, 1'b0, 1, ok);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("start_clears_clip", 32'(clipped_cnt), 32'd0);

        // Line (80,60) to (84,60), then the end point is held with line_done high
        wait_idle();
        base = wr_log.size();
        for (int i = 0; i < 5; i++) send(80 + i, 60, i, i == 0, 1, ok);
        line_done = 1'b1;
        for (int i = 0; i < 4; i++) send(84, 60, 4, 1'b0, 1, ok);
        line_done = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (done) break;
            @(posedge clk);
            #1;
        end
        check("line_done_rise", 32'(done), 32'd1);
        check("line_writes", 32'(wr_log.size() - base), 32'd5);
        for (int i = 0; i < 5; i++) begin
            if (base + i < wr_log.size()) check("line_addr", 32'(wr_log[base + i]), 32'(9680 + i));
        end

        // Back-pressure: 8 FIFO entries and 1 output register, then pix_ready falls
        wait_idle();
        bus.fb_ready = 1'b0;
        base = wr_log.size();
        acc  = 0;
        for (int i = 0; i < 10; i++) begin
            send(20 + 2 * i, 7, i, i == 0, 1, ok);
            if (ok) acc++;
        end
        check("bp_accepted", 32'(acc), 32'd9);
        check("bp_pix_ready", 32'(bus.pix_ready), 32'd0);
        for (int k = 0; k < 3; k++) begin
            check("bp_we_held", 32'(bus.fb_we), 32'd1);
            check("bp_addr_stable", 32'(bus.fb_addr), 32'd1140);
            @(posedge clk);
            #1;
        end
        bus.fb_ready = 1'b1;
        send(38, 7, 1, 1'b0, 5, ok);
        check("bp_late_accept", 32'(ok), 32'd1);
        wait_idle();
        check("bp_writes", 32'(wr_log.size() - base), 32'd10);
        for (int i = 0; i < 10; i++) begin
            if (base + i < wr_log.size()) check("bp_order", 32'(wr_log[base + i]), 32'(1140 + 2 * i));
        end

        // Reset mid-line with 4 pixels buffered and fb_we high
        bus.fb_ready = 1'b0;
        send(300, 0, 0, 1'b1, 1, ok);
        for (int i = 0; i < 5; i++) send(40 + i, 9, i, 1'b0, 1, ok);
        check("pre_rst_we", 32'(bus.fb_we), 32'd1);
        check("pre_rst_clip", 32'(clipped_cnt), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("arst_fb_we", 32'(bus.fb_we), 32'd0);
        check("arst_fb_addr", 32'(bus.fb_addr), 32'd0);
        check("arst_fb_data", 32'(bus.fb_data), 32'd0);
        check("arst_clipped", 32'(clipped_cnt), 32'd0);
        check("arst_pix_ready", 32'(bus.pix_ready), 32'd1);
        check("arst_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #3;
        reset        = 1'b1;
        bus.fb_ready = 1'b1;
        base         = wr_count;
        repeat (10) @(posedge clk);
        #1;
        check("post_rst_no_writes", 32'(wr_count - base), 32'd0);
        // History is invalid after reset, so the last coordinate is written again
        send(44, 9, 2, 1'b0, 1, ok);
        repeat (3) @(posedge clk);
        #1;
        check("post_rst_hist", 32'(wr_count - base), 32'd1);
        check("post_rst_addr", 32'(last_addr), 32'd1484);

        // Randomized traffic against the scoreboard
        rx = 0;
        ry = 0;
        for (int n = 0; n < 2000; n++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 10) begin
                rx = int'($urandom_range(160, 511));
                ry = int'($urandom_range(0, 511));
            end else if (r < 20) begin
                rx = int'($urandom_range(0, 511));
                ry = int'($urandom_range(120, 511));
            end else if (r >= 45) begin
                rx = int'($urandom_range(0, 159));
                ry = int'($urandom_range(0, 119));
            end
            bus.pix_valid = ($urandom_range(0, 99) < 70);
            bus.pix_x     = 9'(rx);
            bus.pix_y     = 9'(ry);
            bus.pix_color = COLOR_W'($urandom_range(0, 7));
            bus.fb_ready  = ($urandom_range(0, 99) < 60);
            start         = ($urandom_range(0, 99) < 3);
            line_done     = ($urandom_range(0, 99) < 5);
            @(posedge clk);
            #1;
        end
        bus.pix_valid = 1'b0;
        start         = 1'b0;
        line_done     = 1'b0;
        bus.fb_ready  = 1'b1;
        wait_idle();
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
